// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, SRAM and stall signals around the shared memory port arbiter.
// The slave side is the arbiter; the master side holds the requesters and the SRAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and MEM; data has priority, and a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            r_state, w_stateNext;
    logic [LAT_W-1:0]  r_latCnt, w_latNext;
    logic              r_ownerD, w_ownerNext;
    logic [STV_W-1:0]  r_starveCnt;
    logic              r_ifRvalid, r_dRvalid;
    logic [DATA_W-1:0] r_ifRdata, r_dRdata;

    logic w_canGrant, w_starved, w_ifGnt, w_dGnt, w_capture, w_ifPend, w_dPend;

    assign w_canGrant = (r_state == IDLE) && !rst;
    assign w_starved  = bus.if_req && (r_starveCnt == STV_W'(STARVE_MAX));
    assign w_dGnt     = w_canGrant && bus.d_req && !w_starved;
    assign w_ifGnt    = w_canGrant && bus.if_req && !w_dGnt;
    assign w_ifPend   = (r_state == RD_WAIT) && !r_ownerD;
    assign w_dPend    = (r_state == RD_WAIT) && r_ownerD;

    always_comb begin
        w_stateNext = r_state;
        w_latNext   = r_latCnt;
        w_ownerNext = r_ownerD;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                // Stores complete in the grant cycle; only reads need the wait state.
                if (w_ifGnt || (w_dGnt && !bus.d_we)) begin
                    w_stateNext = RD_WAIT;
                    w_latNext   = LAT_W'(MEM_LAT);
                    w_ownerNext = w_dGnt;
                end
            end
            RD_WAIT: begin
                if (r_latCnt == LAT_W'(1)) begin
                    w_stateNext = IDLE;
                    w_latNext   = '0;
                    w_capture   = 1'b1;
                end else begin
                    w_latNext = r_latCnt - LAT_W'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_latCnt <= '0;
            r_ownerD <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_latCnt <= w_latNext;
            r_ownerD <= w_ownerNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.if_req || w_ifGnt) begin
            r_starveCnt <= '0;
        end else if (w_dGnt && (r_starveCnt != STV_W'(STARVE_MAX))) begin
            r_starveCnt <= r_starveCnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifRvalid <= 1'b0;
            r_dRvalid  <= 1'b0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
        end else begin
            r_ifRvalid <= w_capture && !r_ownerD;
            r_dRvalid  <= w_capture && r_ownerD;
            if (w_capture && !r_ownerD) r_ifRdata <= bus.mem_rdata;
            if (w_capture && r_ownerD)  r_dRdata  <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = w_ifGnt;
    assign bus.d_gnt     = w_dGnt;
    assign bus.if_rvalid = r_ifRvalid;
    assign bus.d_rvalid  = r_dRvalid;
    assign bus.if_rdata  = r_ifRdata;
    assign bus.d_rdata   = r_dRdata;

    assign bus.mem_en    = w_ifGnt || w_dGnt;
    assign bus.mem_wen   = w_dGnt && bus.d_we;
    assign bus.mem_addr  = w_dGnt ? bus.d_addr : (w_ifGnt ? bus.if_addr : '0);
    assign bus.mem_wdata = w_dGnt ? bus.d_wdata : '0;

    assign bus.stall_if  = !rst && ((bus.if_req && !w_ifGnt) || w_ifPend);
    assign bus.stall_mem = !rst && ((bus.d_req && !w_dGnt) || w_dPend);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-level reference model predicts grants,
// SRAM pins and stalls, and a scoreboard queue checks every returned read.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int          due;
        bit          ownerD;
        logic [63:0] data;
    } exp_rd_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } sram_rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    exp_rd_t     expQ[$];
    sram_rd_t    sramQ[$];
    logic [63:0] refMem[int];
    logic [63:0] sramMem[int];

    int readyCycle = 0;
    int starve     = 0;
    bit pendOwnerD = 1'b0;
    int pendFrom   = -1;
    int pendTo     = -2;
    int storeAddr  = 0;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cycle, got, exp);
        end
    endtask

    function automatic logic [63:0] initWord(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {16'hA5A5, a16, 16'h5A5A, ~a16};
    endfunction

    function automatic logic [63:0] refRead(input int a);
        if (!refMem.exists(a)) refMem[a] = initWord(a);
        return refMem[a];
    endfunction

    function automatic logic [63:0] sramRead(input int a);
        if (!sramMem.exists(a)) sramMem[a] = initWord(a);
        return sramMem[a];
    endfunction

    // Behavioural SRAM: follows the DUT pins and returns read data MEM_LAT cycles after issue.
    always @(negedge clk) begin
        sram_rd_t s;
        if (bus.mem_en && bus.mem_wen) begin
            sramMem[int'(bus.mem_addr)] = bus.mem_wdata;
        end else if (bus.mem_en) begin
            s.due  = cycle + MEM_LAT;
            s.data = sramRead(int'(bus.mem_addr));
            sramQ.push_back(s);
        end
        if (sramQ.size() > 0 && sramQ[0].due == cycle) begin
            bus.mem_rdata = sramQ[0].data;
            void'(sramQ.pop_front());
        end else begin
            bus.mem_rdata = {$urandom, $urandom};
        end
    end

    // Reference model: arbitration rules, busy window and stall windows from cycle arithmetic.
    always @(negedge clk) begin
        bit expD, expI, starvedNow, ifPend, dPend;
        exp_rd_t e;
        if (rst) begin
            checkOutput("outputs_in_reset",
                {58'd0, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_wen, bus.stall_if, bus.stall_mem}, 64'd0);
            readyCycle = cycle + 1;
            starve     = 0;
            pendTo     = -2;
            while (expQ.size() > 0 && expQ[expQ.size()-1].due > cycle) void'(expQ.pop_back());
        end else begin
            starvedNow = bus.if_req && (starve == STARVE_MAX);
            expD   = (cycle >= readyCycle) && bus.d_req && !starvedNow;
            expI   = (cycle >= readyCycle) && bus.if_req && !expD;
            ifPend = !pendOwnerD && cycle >= pendFrom && cycle <= pendTo;
            dPend  = pendOwnerD && cycle >= pendFrom && cycle <= pendTo;
            checkOutput("grants_if_d", {62'd0, bus.if_gnt, bus.d_gnt}, {62'd0, expI, expD});
            checkOutput("mem_en", 64'(bus.mem_en), 64'(expI || expD));
            checkOutput("mem_wen", 64'(bus.mem_wen), 64'(expD && bus.d_we));
            checkOutput("stall_if", 64'(bus.stall_if), 64'((bus.if_req && !expI) || ifPend));
            checkOutput("stall_mem", 64'(bus.stall_mem), 64'((bus.d_req && !expD) || dPend));
            if (expD) begin
                checkOutput("mem_addr_d", 64'(bus.mem_addr), 64'(bus.d_addr));
                checkOutput("mem_wdata_d", bus.mem_wdata, bus.d_wdata);
            end else if (expI) begin
                checkOutput("mem_addr_if", 64'(bus.mem_addr), 64'(bus.if_addr));
            end else begin
                checkOutput("mem_addr_idle", 64'(bus.mem_addr), 64'd0);
            end
            if (expD && bus.d_we) begin
                refMem[int'(bus.d_addr)] = bus.d_wdata;
            end else if (expD || expI) begin
                e.due      = cycle + MEM_LAT + 1;
                e.ownerD   = expD;
                e.data     = refRead(expD ? int'(bus.d_addr) : int'(bus.if_addr));
                expQ.push_back(e);
                readyCycle = cycle + MEM_LAT + 1;
                pendOwnerD = expD;
                pendFrom   = cycle + 1;
                pendTo     = cycle + MEM_LAT;
            end
            if (!bus.if_req || expI) starve = 0;
            else if (expD && starve < STARVE_MAX) starve++;
        end
    end

    // Scoreboard monitor: every rvalid pulse pops the oldest expected read.
    logic [63:0] holdI = '0;
    logic [63:0] holdD = '0;
    bit rstPrev = 1'b0;
    always @(negedge clk) begin
        exp_rd_t e;
        if (rstPrev) begin
            holdI = '0;
            holdD = '0;
        end
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid cycle %0d got if=%0b d=%0b expected none",
                         cycle, bus.if_rvalid, bus.d_rvalid);
            end else begin
                e = expQ.pop_front();
                checkOutput("rvalid_cycle", 64'(cycle), 64'(e.due));
                checkOutput("rvalid_owner", {62'd0, bus.if_rvalid, bus.d_rvalid},
                            e.ownerD ? 64'd1 : 64'd2);
                checkOutput("rdata", e.ownerD ? bus.d_rdata : bus.if_rdata, e.data);
                if (e.ownerD) holdD = e.data;
                else          holdI = e.data;
            end
        end else if (expQ.size() > 0 && expQ[0].due <= cycle) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_rvalid cycle %0d got none expected rvalid due %0d", cycle, expQ[0].due);
            void'(expQ.pop_front());
        end
        if (!bus.if_rvalid) checkOutput("if_rdata_hold", bus.if_rdata, holdI);
        if (!bus.d_rvalid)  checkOutput("d_rdata_hold", bus.d_rdata, holdD);
        rstPrev = rst;
    end

    // One cycle of requester behaviour; a pending request is held until granted.
    // mode 0 random mix, 1 both loads continuously, 2 store stream, 3 idle.
    task automatic applyStimulus(input int mode);
        bit ifFree, dFree;
        @(negedge clk);
        ifFree = !bus.if_req || bus.if_gnt;
        dFree  = !bus.d_req || bus.d_gnt;
        @(posedge clk);
        #1;
        if (ifFree) begin
            bus.if_req  = (mode == 1) || (mode == 0 && $urandom_range(0, 99) < 50);
            bus.if_addr = 16'($urandom_range(0, 15));
        end
        if (dFree) begin
            bus.d_wdata = {$urandom, $urandom};
            case (mode)
                0: begin
                    bus.d_req  = $urandom_range(0, 99) < 50;
                    bus.d_we   = 1'($urandom_range(0, 1));
                    bus.d_addr = 16'($urandom_range(0, 15));
                end
                1: begin
                    bus.d_req  = 1'b1;
                    bus.d_we   = 1'b0;
                    bus.d_addr = 16'($urandom_range(0, 15));
                end
                2: begin
                    bus.d_req  = 1'b1;
                    bus.d_we   = 1'b1;
                    bus.d_addr = 16'(storeAddr);
                    storeAddr++;
                end
                default: begin
                    bus.d_req  = 1'b0;
                    bus.d_we   = 1'b0;
                    bus.d_addr = '0;
                end
            endcase
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        repeat (3)  applyStimulus(3);
        repeat (8)  applyStimulus(2);
        repeat (6)  applyStimulus(3);
        repeat (30) applyStimulus(1);
        repeat (10) applyStimulus(3);

        // Load granted, then reset while it is still in flight.
        @(posedge clk);
        #1;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'd3;
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 16'd5;

        repeat (400) applyStimulus(0);
        repeat (15)  applyStimulus(3);
        @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
